// File: rtl/gba_pad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : gba_pad_scanner
//  Description : Polls an SNES-protocol serial gamepad (latch + 16 shift
//                clocks), validates and debounces each frame, and drives the
//                active-high KeyA..KeyL inputs of the GBA joypad block.
//  Revision    : 1.0 - initial release
// ============================================================================
module gba_pad_scanner #(
   parameter int CLK_DIV        = 16,      // mclk cycles per pad_clk half-period (>= 4)
   parameter int POLL_PERIOD    = 262144,  // idle mclk cycles between frames (> 0)
   parameter int DEBOUNCE_POLLS = 2        // identical valid frames before update (1..15)
) (
   input  logic mclk,
   input  logic gb_bus_rst,
   input  logic enable,
   input  logic pad_data,
   output logic pad_latch,
   output logic pad_clk,
   output logic KeyA,
   output logic KeyB,
   output logic KeySelect,
   output logic KeyStart,
   output logic KeyRight,
   output logic KeyLeft,
   output logic KeyUp,
   output logic KeyDown,
   output logic KeyR,
   output logic KeyL,
   output logic frame_done,
   output logic frame_err
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int PH_W  = $clog2(2 * CLK_DIV);

   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);
   localparam logic [PH_W-1:0]  PH_HI_LAST = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_LO_LAST = PH_W'(2 * CLK_DIV - 1);
   localparam logic [3:0]       DB_MAX     = 4'(DEBOUNCE_POLLS);
   localparam logic [3:0]       LAST_BIT   = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LATCH = 2'd1,
      S_SHIFT = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [3:0]         bit_q,   bit_d;
   logic [15:0]        shift_q, shift_d;
   logic               latch_q, latch_d;
   logic               pclk_q,  pclk_d;
   logic [9:0]         cand_q,  cand_d;
   logic [3:0]         cnt_q,   cnt_d;
   logic [9:0]         keys_q,  keys_d;
   logic               done_q,  done_d;
   logic               err_q,   err_d;
   logic               meta_q;
   logic               sync_q;

   // Decoded view of the captured frame.  Key vector order (LSB first):
   // A, B, Select, Start, Right, Left, Up, Down, R, L.  Raw bits are
   // active-low; Y (bit 1) and X (bit 9) are not forwarded.
   logic               frame_valid;
   logic [9:0]         frame_keys;

   assign frame_valid = &shift_q[15:12];
   assign frame_keys  = ~{shift_q[10], shift_q[11], shift_q[5], shift_q[4],
                          shift_q[6],  shift_q[7],  shift_q[3], shift_q[2],
                          shift_q[0],  shift_q[8]};

   // Two-flop synchronizer for the asynchronous pad data line.
   always_ff @(posedge mclk or posedge gb_bus_rst) begin
      if (gb_bus_rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= pad_data;
         sync_q <= meta_q;
      end
   end

   // State and datapath registers; reset returns the pad lines to idle at once.
   always_ff @(posedge mclk or posedge gb_bus_rst) begin
      if (gb_bus_rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         phase_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         latch_q <= 1'b0;
         pclk_q  <= 1'b1;
         cand_q  <= '0;
         cnt_q   <= '0;
         keys_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         latch_q <= latch_d;
         pclk_q  <= pclk_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         keys_q  <= keys_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Poll sequencing, serial capture and debounce.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      latch_d = latch_q;
      pclk_d  = pclk_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      keys_d  = keys_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Timer saturates so a late enable starts the poll immediately.
            if (timer_q == TMR_LAST) begin
               if (enable) begin
                  timer_d = '0;
                  phase_d = '0;
                  latch_d = 1'b1;
                  state_d = S_LATCH;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         S_LATCH: begin
            if (phase_q == PH_LO_LAST) begin
               latch_d = 1'b0;
               phase_d = '0;
               bit_d   = '0;
               state_d = S_SHIFT;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end

         S_SHIFT: begin
            phase_d = phase_q + PH_W'(1);
            // Sample at the end of the high phase, long after the pad shifted.
            if (phase_q == PH_HI_LAST) begin
               shift_d[bit_q] = sync_q;
               pclk_d         = 1'b0;
            end
            if (phase_q == PH_LO_LAST) begin
               pclk_d  = 1'b1;
               phase_d = '0;
               if (bit_q == LAST_BIT) begin
                  state_d = S_CHECK;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end

         S_CHECK: begin
            timer_d = '0;
            bit_d   = '0;
            state_d = S_IDLE;
            if (frame_valid) begin
               if (frame_keys == cand_q) begin
                  if (cnt_q != DB_MAX) begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cand_d = frame_keys;
                  cnt_d  = 4'd1;
               end
               if (cnt_d == DB_MAX) begin
                  keys_d = cand_d;
                  done_d = 1'b1;
               end
            end else begin
               err_d = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign pad_latch  = latch_q;
   assign pad_clk    = pclk_q;
   assign KeyA       = keys_q[0];
   assign KeyB       = keys_q[1];
   assign KeySelect  = keys_q[2];
   assign KeyStart   = keys_q[3];
   assign KeyRight   = keys_q[4];
   assign KeyLeft    = keys_q[5];
   assign KeyUp      = keys_q[6];
   assign KeyDown    = keys_q[7];
   assign KeyR       = keys_q[8];
   assign KeyL       = keys_q[9];
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gba_pad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gba_pad_scanner
//  Description : Self-checking bench for gba_pad_scanner with a behavioural
//                SNES pad and a frame-level debounce reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gba_pad_scanner;

   localparam int CLK_DIV        = 4;
   localparam int POLL_PERIOD    = 200;
   localparam int DEBOUNCE_POLLS = 2;

   // Raw bit positions of the pad's press mask.
   localparam logic [11:0] P_B  = 12'h001;
   localparam logic [11:0] P_Y  = 12'h002;
   localparam logic [11:0] P_UP = 12'h010;
   localparam logic [11:0] P_A  = 12'h100;
   localparam logic [11:0] P_X  = 12'h200;

   logic mclk       = 1'b0;
   logic gb_bus_rst = 1'b1;
   logic enable     = 1'b0;
   logic pad_data;
   logic pad_latch, pad_clk;
   logic KeyA, KeyB, KeySelect, KeyStart, KeyRight, KeyLeft, KeyUp, KeyDown, KeyR, KeyL;
   logic frame_done, frame_err;
   logic [9:0] keys;

   logic [15:0] pad_word = 16'h0000;
   logic [15:0] pad_sr   = 16'h0000;

   int tests = 0;
   int fails = 0;

   // Reference model state: history of the most recent valid frames.
   logic [9:0] hist[$];
   logic [9:0] m_keys = '0;

   gba_pad_scanner #(
      .CLK_DIV        (CLK_DIV),
      .POLL_PERIOD    (POLL_PERIOD),
      .DEBOUNCE_POLLS (DEBOUNCE_POLLS)
   ) dut (
      .mclk       (mclk),
      .gb_bus_rst (gb_bus_rst),
      .enable     (enable),
      .pad_data   (pad_data),
      .pad_latch  (pad_latch),
      .pad_clk    (pad_clk),
      .KeyA       (KeyA),
      .KeyB       (KeyB),
      .KeySelect  (KeySelect),
      .KeyStart   (KeyStart),
      .KeyRight   (KeyRight),
      .KeyLeft    (KeyLeft),
      .KeyUp      (KeyUp),
      .KeyDown    (KeyDown),
      .KeyR       (KeyR),
      .KeyL       (KeyL),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   assign keys = {KeyL, KeyR, KeyDown, KeyUp, KeyLeft, KeyRight, KeyStart, KeySelect, KeyB, KeyA};

   always #5 mclk = ~mclk;

   // Pad: loads on latch, shifts on pad_clk rising edge, pull-down beyond bit 15.
   always @(posedge pad_latch or posedge pad_clk) begin
      if (pad_latch) pad_sr <= pad_word;
      else           pad_sr <= {1'b0, pad_sr[15:1]};
   end
   assign pad_data = pad_sr[0];

   // Raw frame: press bits are active-low, ID nibble on top.
   function automatic logic [15:0] raw_of(input logic [11:0] press, input logic [3:0] id);
      return {id, ~press};
   endfunction

   // Key vector {L,R,Down,Up,Left,Right,Start,Select,B,A} of a raw frame.
   function automatic logic [9:0] keys_of(input logic [15:0] raw);
      logic [15:0] p;
      p = ~raw;
      return {p[10], p[11], p[5], p[4], p[6], p[7], p[3], p[2], p[0], p[8]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset(input string tag);
      gb_bus_rst = 1'b1;
      hist.delete();
      m_keys = '0;
      repeat (3) @(posedge mclk);
      #1;
      chk({tag, "/rst_latch"}, 32'(pad_latch), 32'd0);
      chk({tag, "/rst_clk"},   32'(pad_clk),   32'd1);
      chk({tag, "/rst_keys"},  32'(keys),      32'd0);
      chk({tag, "/rst_pulse"}, 32'({frame_done, frame_err}), 32'd0);
      @(negedge mclk);
      gb_bus_rst = 1'b0;
   endtask

   // Counts cycles from the first clocked cycle after reset release to the latch.
   task automatic check_first_latch(input string tag);
      int c;
      c = 0;
      @(posedge mclk); #1;
      while (!pad_latch && c < 1000) begin
         @(posedge mclk); #1;
         c++;
      end
      chk(tag, 32'(c), 32'd199);
   endtask

   // Runs one poll end to end and compares it with the reference model.
   task automatic do_frame(input logic [15:0] raw, input bit drop_en, input string tag);
      int t, n, clk_low_latch, lows, run, minrun, maxrun, done_at, err_at, ndone, nerr;
      logic [9:0] keys_before, keys_pre, nk;
      bit valid, exp_done, all_eq;
      pad_word = raw;
      t = 0;
      while (!pad_latch && t < 2000) begin
         @(posedge mclk); #1;
         t++;
      end
      chk({tag, "/latch_seen"}, 32'(pad_latch), 32'd1);
      if (!pad_latch) return;
      if (drop_en) enable = 1'b0;
      keys_before = keys;
      n = 0; clk_low_latch = 0;
      while (pad_latch && n < 100) begin
         if (!pad_clk) clk_low_latch++;
         n++;
         @(posedge mclk); #1;
      end
      chk({tag, "/latch_len"}, 32'(n), 32'd8);
      chk({tag, "/clk_in_latch"}, 32'(clk_low_latch), 32'd0);
      lows = 0; run = 0; minrun = 99; maxrun = 0;
      done_at = -1; err_at = -1; ndone = 0; nerr = 0; keys_pre = '0;
      for (int i = 0; i < 150; i++) begin
         if (!pad_clk) run++;
         else if (run > 0) begin
            lows++;
            if (run < minrun) minrun = run;
            if (run > maxrun) maxrun = run;
            run = 0;
         end
         if (frame_done) begin ndone++; if (done_at < 0) done_at = i; end
         if (frame_err)  begin nerr++;  if (err_at  < 0) err_at  = i; end
         if (i == 128) keys_pre = keys;
         @(posedge mclk); #1;
      end
      chk({tag, "/clk_pulses"}, 32'(lows), 32'd16);
      chk({tag, "/clk_width"}, 32'({minrun[7:0], maxrun[7:0]}), 32'h0404);
      // Reference: outputs follow when the last DEBOUNCE_POLLS valid frames agree.
      valid = (raw[15:12] == 4'hF);
      exp_done = 1'b0;
      if (valid) begin
         nk = keys_of(raw);
         hist.push_back(nk);
         if (hist.size() > DEBOUNCE_POLLS) void'(hist.pop_front());
         all_eq = (hist.size() == DEBOUNCE_POLLS);
         foreach (hist[j]) if (hist[j] != nk) all_eq = 1'b0;
         if (all_eq) begin
            exp_done = 1'b1;
            m_keys = nk;
         end
      end
      chk({tag, "/done_cnt"}, 32'(ndone), 32'(exp_done));
      chk({tag, "/err_cnt"},  32'(nerr),  32'(!valid));
      if (exp_done) chk({tag, "/done_time"}, 32'(done_at), 32'd129);
      if (!valid)   chk({tag, "/err_time"},  32'(err_at),  32'd129);
      chk({tag, "/keys_hold"}, 32'(keys_pre), 32'(keys_before));
      chk({tag, "/keys"},      32'(keys),     32'(m_keys));
   endtask

   initial begin
      logic [15:0] ra, rb, rc, rr;
      logic [11:0] pa, pb;
      int lat, g;

      // 1. A + Up held; outputs change only on the second frame.
      enable = 1'b1;
      rc = raw_of(P_A | P_UP, 4'hF);
      pad_word = rc;
      apply_reset("t1");
      check_first_latch("t1/first_latch");
      do_frame(rc, 1'b0, "t1/f1");
      chk("t1/f1_keys_zero", 32'(keys), 32'd0);
      do_frame(rc, 1'b0, "t1/f2");
      chk("t1/f2_keys", 32'(keys), 32'h041);

      // 2. Absent pad: pull-down gives all-zero frames.
      pad_word = 16'h0000;
      apply_reset("t2");
      for (int f = 0; f < 3; f++) do_frame(16'h0000, 1'b0, "t2/absent");
      chk("t2/keys_zero", 32'(keys), 32'd0);

      // 3. Alternating presses never settle; a stable press then does.
      g = 0;
      do begin
         pa = 12'($urandom_range(1, 4095));
         pb = 12'($urandom_range(1, 4095));
         g++;
      end while (keys_of(raw_of(pa, 4'hF)) == keys_of(raw_of(pb, 4'hF)) && g < 100);
      ra = raw_of(pa, 4'hF);
      rb = raw_of(pb, 4'hF);
      for (int f = 0; f < 4; f++) do_frame((f % 2 == 0) ? ra : rb, 1'b0, "t3/alt");
      chk("t3/alt_keys", 32'(keys), 32'd0);
      rc = raw_of(12'($urandom) | P_A, 4'hF);
      do_frame(rc, 1'b0, "t3/stable1");
      do_frame(rc, 1'b0, "t3/stable2");
      chk("t3/stable_keys", 32'(keys), 32'(keys_of(rc)));

      // 4. Reset during bit 7 of the shift sequence.
      lat = 0;
      while (!pad_latch && lat < 2000) begin @(posedge mclk); #1; lat++; end
      while (pad_latch && lat < 2200)  begin @(posedge mclk); #1; lat++; end
      chk("t4/reached_shift", 32'(lat < 2200), 32'd1);
      repeat (61) @(posedge mclk);
      #1;
      chk("t4/bit7_low", 32'(pad_clk), 32'd0);
      #3 gb_bus_rst = 1'b1;
      #1;
      chk("t4/async_latch", 32'(pad_latch), 32'd0);
      chk("t4/async_clk",   32'(pad_clk),   32'd1);
      chk("t4/async_keys",  32'(keys),      32'd0);
      hist.delete();
      m_keys = '0;
      repeat (2) @(posedge mclk);
      @(negedge mclk);
      gb_bus_rst = 1'b0;
      check_first_latch("t4/first_latch");
      do_frame(rc, 1'b0, "t4/after1");
      do_frame(rc, 1'b0, "t4/after2");

      // 5. enable dropped during LATCH: frame completes, then polling pauses.
      rr = raw_of(P_B, 4'hF);
      do_frame(rr, 1'b1, "t5/drop");
      lat = 0;
      for (int i = 0; i < 1000; i++) begin
         if (pad_latch) lat++;
         @(posedge mclk); #1;
      end
      chk("t5/no_latch", 32'(lat), 32'd0);
      enable = 1'b1;
      @(posedge mclk); #1;
      chk("t5/resume_latch", 32'(pad_latch), 32'd1);
      do_frame(rr, 1'b0, "t5/resume");

      // 6. Only Y and X pressed: valid frames, keys stay clear, done still pulses.
      rr = raw_of(P_Y | P_X, 4'hF);
      pad_word = rr;
      apply_reset("t6");
      check_first_latch("t6/first_latch");
      do_frame(rr, 1'b0, "t6/f1");
      do_frame(rr, 1'b0, "t6/f2");
      chk("t6/keys_zero", 32'(keys), 32'd0);

      // Randomized frames, some with corrupt ID bits, some repeated.
      rr = raw_of(12'($urandom), 4'hF);
      for (int f = 0; f < 8; f++) begin
         if ($urandom_range(0, 2) != 0)
            rr = raw_of(12'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
         do_frame(rr, 1'b0, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
